// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the two-requester RAM
//               port arbiter: owner encoding and the read-owner pipeline
//               entry carried alongside each outstanding read.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_DEFAULT_AW = 6;
    localparam int c_DEFAULT_DW = 8;

    // Which requester a read belongs to.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // One slot of the read-owner pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } pipe_entry_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter. A lone requester is always
//               granted; on contention the side named by the pointer wins.
//               After every grant the pointer moves to the side that was not
//               granted, so contending requesters alternate.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset (pointer favours req[0])
//               req  - request vector, bit 0 = A, bit 1 = B
//               gnt  - one-hot (or zero) grant vector, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0 -> A has priority on contention, 1 -> B has priority.
    logic r_ptr;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = r_ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // Granting A hands priority to B and vice versa; idle cycles hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|gnt) begin
            r_ptr <= gnt[0];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous RAM port between requesters A and B.
//               Round-robin arbitration, registered command issue, owner
//               tracking through the RAM read latency and routing of the
//               read data back to the issuing requester. Also keeps a
//               saturating count of contention cycles.
// Ports       : clk, rst                       - clock, async active-high reset
//               a_valid/a_ready/a_we/a_addr/a_wdata - requester A command
//               b_valid/b_ready/b_we/b_addr/b_wdata - requester B command
//               mem_addr/mem_wdata/mem_we/mem_re    - RAM command (registered)
//               mem_q                          - RAM registered read data
//               a_rsp_valid/b_rsp_valid        - one-cycle read response pulses
//               rsp_data                       - shared read response data
//               conflict_cnt                   - saturating contention counter
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = c_DEFAULT_AW,
    parameter int DW  = c_DEFAULT_DW,
    parameter int LAT = 1,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,

    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_q,

    output logic          a_rsp_valid,
    output logic          b_rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [CW-1:0] conflict_cnt
);

    generate
        if (LAT < 1 || LAT > 3) begin : g_bad_lat
            $error("mem_port_arbiter: LAT must be in 1..3");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration. Requests are masked while reset is held so that no
    // ready is ever shown during reset.
    // ------------------------------------------------------------------
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_accept;
    logic          w_sel_b;
    logic          w_cmd_we;
    logic [AW-1:0] w_cmd_addr;
    logic [DW-1:0] w_cmd_wdata;
    owner_e        w_owner;

    assign w_req = rst ? 2'b00 : {b_valid, a_valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign a_ready     = w_gnt[0];
    assign b_ready     = w_gnt[1];
    assign w_accept    = |w_gnt;
    assign w_sel_b     = w_gnt[1];
    assign w_cmd_we    = w_sel_b ? b_we    : a_we;
    assign w_cmd_addr  = w_sel_b ? b_addr  : a_addr;
    assign w_cmd_wdata = w_sel_b ? b_wdata : a_wdata;
    assign w_owner     = w_sel_b ? OWN_B   : OWN_A;

    // ------------------------------------------------------------------
    // Registered command issue. Enables pulse for one cycle per accept;
    // address and data hold between accepts.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            mem_we <= w_accept &  w_cmd_we;
            mem_re <= w_accept & ~w_cmd_we;
            if (w_accept) begin
                mem_addr  <= w_cmd_addr;
                mem_wdata <= w_cmd_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner pipeline. Slot 0 is loaded on the accept edge (in step with
    // mem_re); slot LAT is seen on the edge at which mem_q is valid, so
    // the response is registered from it.
    // ------------------------------------------------------------------
    pipe_entry_t r_pipe [0:LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: w_accept & ~w_cmd_we, owner: w_owner};
            for (int i = 1; i <= LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing. rsp_data only updates when a response is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            rsp_data    <= '0;
        end else begin
            a_rsp_valid <= r_pipe[LAT].valid & (r_pipe[LAT].owner == OWN_A);
            b_rsp_valid <= r_pipe[LAT].valid & (r_pipe[LAT].owner == OWN_B);
            if (r_pipe[LAT].valid) begin
                rsp_data <= mem_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Contention statistics: raw valids, saturating at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != {CW{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_dut1 with default parameters (LAT=1, CW=8) and u_dut2 with
//               LAT=3, CW=2. Each has its own behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_we, b_valid, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    // Instance 1 (LAT=1, CW=8)
    logic          a_ready1, b_ready1, mem_we1, mem_re1, a_rsp1, b_rsp1;
    logic [AW-1:0] mem_addr1;
    logic [DW-1:0] mem_wdata1, mem_q1, rsp_data1;
    logic [7:0]    cnt1;

    // Instance 2 (LAT=3, CW=2)
    logic          a_ready2, b_ready2, mem_we2, mem_re2, a_rsp2, b_rsp2;
    logic [AW-1:0] mem_addr2;
    logic [DW-1:0] mem_wdata2, mem_q2, rsp_data2;
    logic [1:0]    cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter u_dut1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_re(mem_re1),
        .mem_q(mem_q1), .a_rsp_valid(a_rsp1), .b_rsp_valid(b_rsp1), .rsp_data(rsp_data1),
        .conflict_cnt(cnt1)
    );

    mem_port_arbiter #(.LAT(3), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready2), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_re(mem_re2),
        .mem_q(mem_q2), .a_rsp_valid(a_rsp2), .b_rsp_valid(b_rsp2), .rsp_data(rsp_data2),
        .conflict_cnt(cnt2)
    );

    // Behavioural RAMs: q registered on the edge that samples re, plus
    // two extra stages for the LAT=3 instance.
    logic [DW-1:0] ram1 [0:63];
    logic [DW-1:0] ram2 [0:63];
    logic [DW-1:0] q2_s0, q2_s1;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram1[i] = '0;
            ram2[i] = '0;
        end
        mem_q1 = '0;
        q2_s0  = '0;
        q2_s1  = '0;
        mem_q2 = '0;
    end

    always @(posedge clk) begin
        if (mem_we1) ram1[mem_addr1] <= mem_wdata1;
        if (mem_re1) mem_q1 <= ram1[mem_addr1];
        if (mem_we2) ram2[mem_addr2] <= mem_wdata2;
        if (mem_re2) q2_s0 <= ram2[mem_addr2];
        q2_s1  <= q2_s0;
        mem_q2 <= q2_s1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset with both valids high ----------------
        rst = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        a_we = 1'b0;    b_we = 1'b0;
        a_addr = '0;    b_addr = '0;
        a_wdata = '0;   b_wdata = '0;
        repeat (3) tick;
        check_eq("rst_a_ready",   32'(a_ready1),   0);
        check_eq("rst_b_ready",   32'(b_ready1),   0);
        check_eq("rst_mem_we",    32'(mem_we1),    0);
        check_eq("rst_mem_re",    32'(mem_re1),    0);
        check_eq("rst_mem_addr",  32'(mem_addr1),  0);
        check_eq("rst_mem_wdata", 32'(mem_wdata1), 0);
        check_eq("rst_a_rsp",     32'(a_rsp1),     0);
        check_eq("rst_b_rsp",     32'(b_rsp1),     0);
        check_eq("rst_rsp_data",  32'(rsp_data1),  0);
        check_eq("rst_cnt1",      32'(cnt1),       0);
        check_eq("rst_cnt2",      32'(cnt2),       0);

        rst = 1'b0;
        #1;
        check_eq("rel_a_ready", 32'(a_ready1), 1);
        check_eq("rel_b_ready", 32'(b_ready1), 0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick;
        check_eq("rel_cnt1", 32'(cnt1), 0);

        // ---------------- A write 0x05=0xA5, then A read 0x05 ----------------
        a_valid = 1'b1; a_we = 1'b1; a_addr = 6'h05; a_wdata = 8'hA5;
        #1;
        check_eq("wr_a_ready", 32'(a_ready1), 1);
        tick;
        check_eq("wr_mem_we",    32'(mem_we1),    1);
        check_eq("wr_mem_re",    32'(mem_re1),    0);
        check_eq("wr_mem_addr",  32'(mem_addr1),  32'h05);
        check_eq("wr_mem_wdata", 32'(mem_wdata1), 32'hA5);
        a_we = 1'b0;
        #1;
        check_eq("rd_a_ready", 32'(a_ready1), 1);
        tick;
        check_eq("rd_mem_re",   32'(mem_re1),   1);
        check_eq("rd_mem_we",   32'(mem_we1),   0);
        check_eq("rd_mem_addr", 32'(mem_addr1), 32'h05);
        a_valid = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick;
            if (j == 1) check_eq("rd_mem_re_drop", 32'(mem_re1), 0);
            check_eq("rd_a_rsp1", 32'(a_rsp1), (j == 2) ? 1 : 0);
            check_eq("rd_b_rsp1", 32'(b_rsp1), 0);
            if (j >= 2) check_eq("rd_data1", 32'(rsp_data1), 32'hA5);
            check_eq("rd_a_rsp2_lat3", 32'(a_rsp2), (j == 4) ? 1 : 0);
            if (j == 4) check_eq("rd_data2_lat3", 32'(rsp_data2), 32'hA5);
        end

        // ---------------- B write 0x3F=0x5A, then A read 0x3F ----------------
        b_valid = 1'b1; b_we = 1'b1; b_addr = 6'h3F; b_wdata = 8'h5A;
        #1;
        check_eq("xw_b_ready", 32'(b_ready1), 1);
        check_eq("xw_a_ready", 32'(a_ready1), 0);
        tick;
        check_eq("xw_mem_we",    32'(mem_we1),    1);
        check_eq("xw_mem_addr",  32'(mem_addr1),  32'h3F);
        check_eq("xw_mem_wdata", 32'(mem_wdata1), 32'h5A);
        b_valid = 1'b0; b_we = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 6'h3F;
        #1;
        check_eq("xr_a_ready", 32'(a_ready1), 1);
        tick;
        check_eq("xr_mem_re", 32'(mem_re1), 1);
        a_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick;
            check_eq("xr_a_rsp1", 32'(a_rsp1), (j == 2) ? 1 : 0);
            check_eq("xr_b_rsp1", 32'(b_rsp1), 0);
            if (j == 2) check_eq("xr_data1", 32'(rsp_data1), 32'h5A);
            check_eq("xr_a_rsp2", 32'(a_rsp2), (j == 4) ? 1 : 0);
            if (j == 4) check_eq("xr_data2", 32'(rsp_data2), 32'h5A);
        end

        // ---------------- reset while an A read is in flight ----------------
        a_valid = 1'b1; a_we = 1'b0; a_addr = 6'h05;
        tick;
        a_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mrst_rsp_data", 32'(rsp_data1), 0);
        check_eq("mrst_mem_re",   32'(mem_re1),   0);
        tick;
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick;
            check_eq("mrst_a_rsp1", 32'(a_rsp1), 0);
            check_eq("mrst_a_rsp2", 32'(a_rsp2), 0);
        end
        check_eq("mrst_cnt1", 32'(cnt1), 0);

        // ---------------- contention: both read for 6 cycles ----------------
        a_we = 1'b0; b_we = 1'b0;
        a_addr = 6'h05; b_addr = 6'h3F;
        for (int k = 0; k <= 9; k++) begin
            a_valid = (k < 6); b_valid = (k < 6);
            #1;
            if (k < 6) begin
                check_eq("ct_a_ready", 32'(a_ready1), (k % 2 == 0) ? 1 : 0);
                check_eq("ct_b_ready", 32'(b_ready1), (k % 2 == 1) ? 1 : 0);
            end
            tick;
            check_eq("ct_mem_re", 32'(mem_re1), (k < 6) ? 1 : 0);
            if (k < 6) check_eq("ct_mem_addr", 32'(mem_addr1), (k % 2 == 0) ? 32'h05 : 32'h3F);
            check_eq("ct_a_rsp1", 32'(a_rsp1), (k >= 2 && k <= 7 && k % 2 == 0) ? 1 : 0);
            check_eq("ct_b_rsp1", 32'(b_rsp1), (k >= 2 && k <= 7 && k % 2 == 1) ? 1 : 0);
            if (k >= 2 && k <= 7)
                check_eq("ct_data1", 32'(rsp_data1), (k % 2 == 0) ? 32'hA5 : 32'h5A);
            check_eq("ct_a_rsp2", 32'(a_rsp2), (k >= 4 && k % 2 == 0) ? 1 : 0);
            check_eq("ct_b_rsp2", 32'(b_rsp2), (k >= 4 && k % 2 == 1) ? 1 : 0);
            if (k >= 4)
                check_eq("ct_data2", 32'(rsp_data2), (k % 2 == 0) ? 32'hA5 : 32'h5A);
            if (k == 2) check_eq("ct_cnt2_at3", 32'(cnt2), 3);
        end
        check_eq("ct_cnt1",      32'(cnt1),      6);
        check_eq("ct_cnt2_sat",  32'(cnt2),      3);
        check_eq("ct_data_hold", 32'(rsp_data1), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
